uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 141 ++++++++++++++
 tb/tb_uart_rx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, 2-flop input synchronizer, mid-bit sampling.
// State | meaning: IDLE wait for start edge | START verify start at half bit | DATA shift 8 bits | STOP check stop bit | WAIT_IDLE wait for line high
module uart_rx #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Active
);

  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] HALF = 8'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t      r_state;
  logic        r_sync1;
  logic        r_sync2;
  logic [7:0]  r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic [1:0]  r_warm;
  logic        r_armed;
  logic        r_dv;
  logic        r_err;
  logic        r_active;
  logic [7:0]  r_byte;

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      r_state  <= S_IDLE;
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_cnt    <= 8'd0;
      r_idx    <= 3'd0;
      r_shift  <= 8'h00;
      r_warm   <= 2'd0;
      r_armed  <= 1'b0;
      r_dv     <= 1'b0;
      r_err    <= 1'b0;
      r_active <= 1'b0;
      r_byte   <= 8'h00;
    end else begin
      r_sync1 <= i_Rx_Serial;
      r_sync2 <= r_sync1;
      r_dv    <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= 8'd0;
          r_idx <= 3'd0;
          // After reset the synchronizer holds its reset value for two edges;
          // only then can the real line level be trusted to arm the receiver.
          if (!r_armed) begin
            if (r_warm != 2'd2) begin
              r_warm <= r_warm + 2'd1;
            end else if (r_sync2) begin
              r_armed <= 1'b1;
            end else begin
              r_state  <= S_WAIT_IDLE;
              r_active <= 1'b1;
            end
          end else if (!r_sync2) begin
            r_state  <= S_START;
            r_active <= 1'b1;
          end
        end
        S_START: begin
          if (r_cnt == HALF) begin
            r_cnt <= 8'd0;
            if (!r_sync2) begin
              r_state <= S_DATA;
            end else begin
              r_state  <= S_IDLE;
              r_active <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DATA: begin
          if (r_cnt == LAST) begin
            r_cnt          <= 8'd0;
            r_shift[r_idx] <= r_sync2;
            if (r_idx == 3'd7) begin
              r_idx   <= 3'd0;
              r_state <= S_STOP;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_STOP: begin
          if (r_cnt == LAST) begin
            r_cnt <= 8'd0;
            if (r_sync2) begin
              r_byte   <= r_shift;
              r_dv     <= 1'b1;
              r_state  <= S_IDLE;
              r_active <= 1'b0;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WAIT_IDLE: begin
          if (r_sync2) begin
            r_armed  <= 1'b1;
            r_state  <= S_IDLE;
            r_active <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign o_Rx_DV        = r_dv;
  assign o_Rx_Byte      = r_byte;
  assign o_Rx_Frame_Err = r_err;
  assign o_Rx_Active    = r_active;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three instances (2, 4, 8 clocks per bit) driven by a
// frame-level line model, with a queue scoreboard checked by a pulse monitor.
module tb_uart_rx;

  typedef struct packed {
    logic       err;
    logic [7:0] b;
    int         t0;
  } exp_t;

  logic       clk = 1'b0;
  logic [2:0] rst_n;
  logic [2:0] line;
  logic [2:0] dv;
  logic [2:0] ferr;
  logic [2:0] act;
  logic [7:0] rbyte [3];

  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  exp_t       exp_q [3][$];
  logic [7:0] model_byte [3];
  logic [7:0] prev_byte [3];
  logic [2:0] prev_act;
  logic [2:0] rst_at_edge;
  int         ndv [3];
  int         nerr [3];
  int         nfall [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int P = (g == 0) ? 2 : ((g == 1) ? 4 : 8);
    uart_rx #(.CLKS_PER_BIT(P)) u_dut (
      .i_Clock       (clk),
      .i_Rst_n       (rst_n[g]),
      .i_Rx_Serial   (line[g]),
      .o_Rx_DV       (dv[g]),
      .o_Rx_Byte     (rbyte[g]),
      .o_Rx_Frame_Err(ferr[g]),
      .o_Rx_Active   (act[g])
    );
  end

  function automatic int cpb(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 4 : 8);
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Serialise one 8N1 frame; when push is set the expected outcome is queued.
  task automatic send_frame(input int g, input logic [7:0] b, input logic stop, input logic push);
    logic [9:0] fr;
    exp_t       e;
    fr = {stop, b, 1'b0};
    if (push) begin
      e.err = ~stop;
      e.b   = stop ? b : model_byte[g];
      e.t0  = cyc;
      exp_q[g].push_back(e);
      if (stop) model_byte[g] = b;
    end
    for (int i = 0; i < 10; i++) begin
      line[g] = fr[i];
      cycles(cpb(g));
    end
  endtask

  task automatic mon_step();
    exp_t e;
    int   lat;
    int   want;
    for (int g = 0; g < 3; g++) begin
      if (!rst_at_edge[g]) begin
        checks++;
        if (dv[g] || ferr[g] || act[g] || rbyte[g] != 8'h00) begin
          failures++;
          $display("FAIL reset_state inst=%0d got dv=%b err=%b act=%b byte=%h want 0 0 0 00",
                   g, dv[g], ferr[g], act[g], rbyte[g]);
        end
      end else if (dv[g] || ferr[g]) begin
        checks++;
        if (dv[g] && ferr[g]) begin
          failures++;
          $display("FAIL dv_and_err inst=%0d got both high want exclusive", g);
        end else if (exp_q[g].size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse inst=%0d got dv=%b err=%b byte=%h want none",
                   g, dv[g], ferr[g], rbyte[g]);
        end else begin
          e = exp_q[g].pop_front();
          if (ferr[g] != e.err || rbyte[g] != e.b) begin
            failures++;
            $display("FAIL frame inst=%0d got err=%b byte=%h want err=%b byte=%h",
                     g, ferr[g], rbyte[g], e.err, e.b);
          end
          // 2 sync stages + half bit + 9 bit periods + 1 output register
          lat  = cyc - e.t0;
          want = 2 + (cpb(g) - 1) / 2 + 9 * cpb(g) + 1;
          checks++;
          if (lat < want - 1 || lat > want + 1) begin
            failures++;
            $display("FAIL latency inst=%0d got=%0d want=%0d+-1", g, lat, want);
          end
        end
        if (dv[g]) begin
          ndv[g]++;
          checks++;
          if (act[g]) begin
            failures++;
            $display("FAIL active_at_dv inst=%0d got=1 want=0", g);
          end
        end
        if (ferr[g]) nerr[g]++;
      end else if (rbyte[g] != prev_byte[g]) begin
        checks++;
        failures++;
        $display("FAIL byte_changed inst=%0d got=%h want=%h", g, rbyte[g], prev_byte[g]);
      end
      if (prev_act[g] && !act[g]) nfall[g]++;
      prev_act[g]  = act[g];
      prev_byte[g] = rbyte[g];
    end
  endtask

  initial begin
    int dv_before;
    int err_before;
    int fall_before;
    logic [7:0] b;

    rst_n       = 3'b000;
    line        = 3'b111;
    prev_act    = 3'b000;
    rst_at_edge = 3'b111;
    for (int g = 0; g < 3; g++) begin
      model_byte[g] = 8'h00;
      prev_byte[g]  = 8'h00;
      ndv[g]        = 0;
      nerr[g]       = 0;
      nfall[g]      = 0;
    end

    fork
      forever begin
        @(posedge clk);
        rst_at_edge = rst_n;
      end
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    @(posedge clk);
    #1;
    cycles(4);
    rst_n = 3'b111;
    cycles(6);

    // single good byte
    send_frame(1, 8'hA5, 1'b1, 1'b1);
    cycles(5);

    // back-to-back frames, no idle gap
    send_frame(1, 8'h00, 1'b1, 1'b1);
    send_frame(1, 8'hFF, 1'b1, 1'b1);
    send_frame(1, 8'h3C, 1'b1, 1'b1);
    cycles(5);

    // stop bit low, then line held low (break), then a good frame
    send_frame(1, 8'h55, 1'b0, 1'b1);
    cycles(40);
    line[1] = 1'b1;
    cycles(5);
    send_frame(1, 8'h12, 1'b1, 1'b1);
    cycles(5);

    // reset pulse during data bit 4 aborts the frame silently
    fork
      send_frame(1, 8'h81, 1'b1, 1'b0);
      begin
        cycles(5 * cpb(1) + 1);
        rst_n[1] = 1'b0;
        cycles(2);
        rst_n[1] = 1'b1;
      end
    join
    model_byte[1] = 8'h00;
    cycles(10);
    chk("post_reset_byte", int'(rbyte[1]), 0);
    send_frame(1, 8'h81, 1'b1, 1'b1);
    cycles(5);

    // glitch on an idle line at 8 clocks per bit
    send_frame(2, 8'h5A, 1'b1, 1'b1);
    cycles(5);
    dv_before  = ndv[2];
    err_before = nerr[2];
    line[2] = 1'b0;
    cycles(2);
    line[2] = 1'b1;
    cycles(20);
    chk("glitch_no_dv", ndv[2], dv_before);
    chk("glitch_no_err", nerr[2], err_before);
    chk("glitch_byte_held", int'(rbyte[2]), 32'h5A);
    chk("glitch_back_idle", int'(act[2]), 0);

    // random stream at the default rate
    fall_before = nfall[0];
    for (int i = 0; i < 100; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(0, b, 1'b1, 1'b1);
      cycles($urandom_range(0, 3));
    end

    for (int i = 0; i < 300 && (exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0; i++)
      cycles(1);
    cycles(5);

    for (int g = 0; g < 3; g++) chk($sformatf("queue_drained_inst%0d", g), exp_q[g].size(), 0);
    chk("stream_dv_count", ndv[0], 100);
    chk("stream_active_falls", nfall[0] - fall_before, 100);
    chk("inst1_dv_count", ndv[1], 6);
    chk("inst1_err_count", nerr[1], 1);
    chk("inst2_dv_count", ndv[2], 1);
    chk("stream_err_count", nerr[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
